// File: rtl/jesd204b_tx_link_ctrl_if.sv
// Lane-side bundle for the JESD204B transmit link controller: control inputs,
// scrambler handshake and the octet stream going to the 8b/10b encoder.
interface jesd204b_tx_link_ctrl_if;
  logic         tx_en;
  logic         sync_n;
  logic [111:0] cfg;
  logic [31:0]  sample_data;
  logic [31:0]  scr_in;
  logic         sample_ready;
  logic         scr_reset_b;
  logic [31:0]  tx_data;
  logic [3:0]   tx_charisk;
  logic [4:0]   lmfc_cnt;
  logic [1:0]   state;
  logic         link_up;

  modport master (
    output tx_en, sync_n, cfg, sample_data, scr_in,
    input  sample_ready, scr_reset_b, tx_data, tx_charisk, lmfc_cnt, state, link_up
  );

  modport slave (
    input  tx_en, sync_n, cfg, sample_data, scr_in,
    output sample_ready, scr_reset_b, tx_data, tx_charisk, lmfc_cnt, state, link_up
  );
endinterface

// File: rtl/jesd204b_tx_link_ctrl.sv
// JESD204B transmit link sequencer for one 32-bit lane (F=4, one frame per clock):
// CGS, ILAS and DATA phases, plus scrambler seed/reset timing.
module jesd204b_tx_link_ctrl #(
  parameter int K        = 32,
  parameter int ILAS_MF  = 4,
  parameter int SCRAMBLE = 1
) (
  input logic clk,
  input logic reset,
  jesd204b_tx_link_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CGS  = 2'd1;
  localparam logic [1:0] ST_ILAS = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  localparam logic [4:0] LMFC_LAST = 5'(K - 1);
  localparam logic [2:0] MF_LAST   = 3'(ILAS_MF - 1);

  logic        sync_meta_q, sync_s_q, sync_prev_q;
  logic [4:0]  lmfc_q, lmfc_d;
  logic [1:0]  state_q, state_d;
  logic [2:0]  mf_q, mf_d;
  logic [31:0] samp_q;
  logic [31:0] tx_data_q, tx_data_d;
  logic [3:0]  charisk_q, charisk_d;
  logic        ready_q, ready_d;
  logic        link_up_q, link_up_d;
  logic        loss_of_sync;
  logic [31:0] payload;

  assign payload = (SCRAMBLE != 0) ? bus.scr_in : samp_q;

  always_comb begin
    lmfc_d       = (lmfc_q == LMFC_LAST) ? 5'd0 : lmfc_q + 5'd1;
    loss_of_sync = !sync_s_q && !sync_prev_q;
    state_d      = state_q;
    mf_d         = mf_q;

    if (!bus.tx_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_CGS;
        ST_CGS: begin
          if (sync_s_q && lmfc_q == LMFC_LAST) begin
            state_d = ST_ILAS;
            mf_d    = 3'd0;
          end
        end
        ST_ILAS: begin
          if (loss_of_sync) begin
            state_d = ST_CGS;
          end else if (lmfc_q == LMFC_LAST) begin
            if (mf_q == MF_LAST) state_d = ST_DATA;
            else                 mf_d    = mf_q + 3'd1;
          end
        end
        default: begin
          if (loss_of_sync) state_d = ST_CGS;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state/frame so they register in step with state.
  always_comb begin
    tx_data_d = 32'd0;
    charisk_d = 4'd0;
    case (state_d)
      ST_CGS: begin
        tx_data_d = 32'hBCBC_BCBC;
        charisk_d = 4'hF;
      end
      ST_ILAS: begin
        for (int i = 0; i < 4; i++) tx_data_d[8*i +: 8] = {lmfc_d, 2'(i), 1'b0};
        if (mf_d == 3'd1) begin
          case (lmfc_d)
            5'd1: begin
              tx_data_d    = {bus.cfg[23:0], 8'h9C};
              charisk_d[0] = 1'b1;
            end
            5'd2: tx_data_d = bus.cfg[55:24];
            5'd3: tx_data_d = bus.cfg[87:56];
            5'd4: tx_data_d[23:0] = bus.cfg[111:88];
            default: ;
          endcase
        end
        if (lmfc_d == 5'd0) begin
          tx_data_d[7:0] = 8'h1C;
          charisk_d[0]   = 1'b1;
        end
        if (lmfc_d == LMFC_LAST) begin
          tx_data_d[31:24] = 8'h7C;
          charisk_d[3]     = 1'b1;
        end
      end
      ST_DATA: tx_data_d = payload;
      default: ;
    endcase

    // Releasing the scrambler two frames early lands sample 0 on the first DATA frame.
    ready_d   = (state_d == ST_DATA) ||
                (state_d == ST_ILAS && mf_d == MF_LAST && lmfc_d >= LMFC_LAST - 5'd1);
    link_up_d = (state_d == ST_DATA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_q <= 1'b0;
      sync_s_q    <= 1'b0;
      sync_prev_q <= 1'b0;
      lmfc_q      <= 5'd0;
      state_q     <= ST_IDLE;
      mf_q        <= 3'd0;
      samp_q      <= 32'd0;
      tx_data_q   <= 32'd0;
      charisk_q   <= 4'd0;
      ready_q     <= 1'b0;
      link_up_q   <= 1'b0;
    end else begin
      sync_meta_q <= bus.sync_n;
      sync_s_q    <= sync_meta_q;
      sync_prev_q <= sync_s_q;
      lmfc_q      <= lmfc_d;
      state_q     <= state_d;
      mf_q        <= mf_d;
      samp_q      <= bus.sample_data;
      tx_data_q   <= tx_data_d;
      charisk_q   <= charisk_d;
      ready_q     <= ready_d;
      link_up_q   <= link_up_d;
    end
  end

  assign bus.tx_data      = tx_data_q;
  assign bus.tx_charisk   = charisk_q;
  assign bus.lmfc_cnt     = lmfc_q;
  assign bus.state        = state_q;
  assign bus.link_up      = link_up_q;
  assign bus.sample_ready = ready_q;
  assign bus.scr_reset_b  = ready_q;

endmodule

// File: tb/tb_jesd204b_tx_link_ctrl.sv
// Testbench for jesd204b_tx_link_ctrl: directed link bring-up, sync loss and
// abort scenarios, checked every cycle against a frame-index based model.
module tb_jesd204b_tx_link_ctrl;
  localparam int K       = 32;
  localparam int ILAS_MF = 4;
  localparam int NGOLD   = 512;
  localparam logic [111:0] CFG_VAL = 112'h0D0C0B0A09080706050403020100;

  logic clk;
  logic reset;
  int   passCount;
  int   checkCount;

  jesd204b_tx_link_ctrl_if bus();

  jesd204b_tx_link_ctrl #(.K(K), .ILAS_MF(ILAS_MF), .SCRAMBLE(1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference self-synchronous scrambler 1 + x^14 + x^15, bit 31 first.
  function automatic logic [46:0] scrStep(input logic [31:0] d, input logic [14:0] st);
    logic [14:0] h;
    logic [31:0] o;
    logic        s;
    h = st;
    o = 32'd0;
    for (int i = 31; i >= 0; i--) begin
      s    = d[i] ^ h[13] ^ h[14];
      o[i] = s;
      h    = {h[13:0], s};
    end
    return {h, o};
  endfunction

  logic [31:0] golden [NGOLD];
  logic [31:0] sampleCnt;
  logic [31:0] scrOut;
  logic [14:0] scrState;

  initial begin
    logic [14:0] st;
    logic [46:0] r;
    st = 15'h7F80;
    for (int k = 0; k < NGOLD; k++) begin
      r         = scrStep(32'(k), st);
      golden[k] = r[31:0];
      st        = r[46:32];
    end
  end

  // Lane scrambler and sample source: sample counter restarts whenever the scrambler is held in reset.
  always @(posedge clk) begin
    logic [46:0] r;
    if (bus.scr_reset_b !== 1'b1) begin
      scrState  <= 15'h7F80;
      scrOut    <= 32'd0;
      sampleCnt <= 32'd0;
    end else begin
      r = scrStep(sampleCnt, scrState);
      scrOut    <= r[31:0];
      scrState  <= r[46:32];
      sampleCnt <= sampleCnt + 32'd1;
    end
  end

  assign bus.sample_data = sampleCnt;
  assign bus.scr_in      = scrOut;
  assign bus.cfg         = CFG_VAL;

  // Expected ILAS word as a function of the frame index since ILAS began.
  function automatic logic [35:0] ilasWord(input int f);
    int          fr, mf, slot;
    logic [31:0] w;
    logic [3:0]  k;
    fr = f % K;
    mf = f / K;
    k  = 4'd0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'((fr * 8 + i * 2) & 255);
    if (mf == 1 && fr >= 1 && fr <= 4) begin
      for (int i = 0; i < 4; i++) begin
        slot = 4 * (fr - 1) + i;
        if (slot == 0) begin
          w[7:0] = 8'h9C;
          k[0]   = 1'b1;
        end else if (slot <= 14) begin
          w[8*i +: 8] = CFG_VAL[8*(slot-1) +: 8];
        end
      end
    end
    if (fr == 0) begin
      w[7:0] = 8'h1C;
      k[0]   = 1'b1;
    end
    if (fr == K - 1) begin
      w[31:24] = 8'h7C;
      k[3]     = 1'b1;
    end
    return {k, w};
  endfunction

  // Behavioural model: absolute tick count, phase start ticks and a sync_n delay line.
  int          tick, ilasStart, dataStart, mode;
  bit          modelValid;
  bit          m1, sS, sP;
  logic [31:0] expData;
  logic [3:0]  expK;
  logic [4:0]  expLmfc;
  logic [1:0]  expState;
  logic        expReady;

  always @(posedge clk) begin
    int        lm;
    bit        loss;
    logic [35:0] iw;
    if (reset) begin
      mode = 0;
      tick = 0;
      m1 = 1'b0; sS = 1'b0; sP = 1'b0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      lm   = tick % K;
      loss = !sS && !sP;
      if (!bus.tx_en) mode = 0;
      else begin
        case (mode)
          0: mode = 1;
          1: if (sS && lm == K - 1) begin mode = 2; ilasStart = tick + 1; end
          2: begin
            if (loss) mode = 1;
            else if (tick + 1 - ilasStart == ILAS_MF * K) begin mode = 3; dataStart = tick + 1; end
          end
          default: if (loss) mode = 1;
        endcase
      end
      sP = sS; sS = m1; m1 = bus.sync_n;
      tick++;
    end
    expLmfc  = 5'(tick % K);
    expState = 2'(mode);
    expData  = 32'd0;
    expK     = 4'd0;
    expReady = 1'b0;
    case (mode)
      1: begin expData = 32'hBCBCBCBC; expK = 4'hF; end
      2: begin
        iw       = ilasWord(tick - ilasStart);
        expData  = iw[31:0];
        expK     = iw[35:32];
        expReady = (tick - ilasStart) >= ILAS_MF * K - 2;
      end
      3: begin
        expData  = (tick - dataStart < NGOLD) ? golden[tick - dataStart] : 32'd0;
        expReady = 1'b1;
      end
      default: ;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("state",        32'(bus.state),        32'(expState));
      checkOutput("lmfc_cnt",     32'(bus.lmfc_cnt),     32'(expLmfc));
      checkOutput("tx_data",      bus.tx_data,           expData);
      checkOutput("tx_charisk",   32'(bus.tx_charisk),   32'(expK));
      checkOutput("sample_ready", 32'(bus.sample_ready), 32'(expReady));
      checkOutput("scr_reset_b",  32'(bus.scr_reset_b),  32'(expReady));
      checkOutput("link_up",      32'(bus.link_up),      32'(expState == 2'd3));
    end
  end

  task automatic applyStimulus(input logic en, input logic sn, input logic rst, input int cycles);
    bus.tx_en  = en;
    bus.sync_n = sn;
    reset      = rst;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitState(input string name, input logic [1:0] s, input int limit);
    int n;
    n = 0;
    while (bus.state !== s && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(bus.state), 32'(s));
  endtask

  initial begin
    int n;
    passCount  = 0;
    checkCount = 0;
    modelValid = 1'b0;
    bus.tx_en  = 1'b0;
    bus.sync_n = 1'b0;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_state",   32'(bus.state),        32'd0);
    checkOutput("rst_tx_data", bus.tx_data,           32'd0);
    checkOutput("rst_ready",   32'(bus.sample_ready), 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 100);
    checkOutput("cgs_state",   32'(bus.state),      32'd1);
    checkOutput("cgs_data",    bus.tx_data,         32'hBCBCBCBC);
    checkOutput("cgs_charisk", 32'(bus.tx_charisk), 32'hF);

    n = 0;
    while (bus.lmfc_cnt !== 5'd10 && n < 40) begin @(negedge clk); n++; end
    checkOutput("lmfc_at_10", 32'(bus.lmfc_cnt), 32'd10);
    bus.sync_n = 1'b1;
    waitState("ilas_entry", 2'd2, 80);
    checkOutput("ilas_lmfc0",  32'(bus.lmfc_cnt),   32'd0);
    checkOutput("ilas_f0",     bus.tx_data,         32'h0604021C);
    checkOutput("ilas_f0_k",   32'(bus.tx_charisk), 32'h1);
    repeat (K + 1) @(negedge clk);
    checkOutput("ilas_mf1_f1", bus.tx_data,         32'h0201009C);
    checkOutput("ilas_mf1_k1", 32'(bus.tx_charisk), 32'h1);
    @(negedge clk);
    checkOutput("ilas_mf1_f2", bus.tx_data,         32'h06050403);
    repeat (2) @(negedge clk);
    checkOutput("ilas_mf1_f4", 32'(bus.tx_data[23:0]), 32'h0D0C0B);

    waitState("data_entry", 2'd3, 200);
    checkOutput("data_first", bus.tx_data,           golden[0]);
    checkOutput("data_link",  32'(bus.link_up),      32'd1);
    checkOutput("data_ready", 32'(bus.sample_ready), 32'd1);

    applyStimulus(1'b1, 1'b1, 1'b0, 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 10);
    checkOutput("glitch_ignored", 32'(bus.state), 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    bus.sync_n = 1'b1;
    waitState("loss_to_cgs", 2'd1, 10);
    checkOutput("loss_scr_rst", 32'(bus.scr_reset_b), 32'd0);
    checkOutput("loss_data",    bus.tx_data,          32'hBCBCBCBC);
    waitState("reilas", 2'd2, 80);
    checkOutput("reilas_lmfc0", 32'(bus.lmfc_cnt), 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b0, 40);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("txen_state", 32'(bus.state),        32'd0);
    checkOutput("txen_data",  bus.tx_data,           32'd0);
    checkOutput("txen_ready", 32'(bus.sample_ready), 32'd0);

    bus.tx_en = 1'b1;
    waitState("data_again", 2'd3, 300);
    applyStimulus(1'b1, 1'b1, 1'b0, 10);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    checkOutput("rst_mid_state", 32'(bus.state),        32'd0);
    checkOutput("rst_mid_data",  bus.tx_data,           32'd0);
    checkOutput("rst_mid_ready", 32'(bus.sample_ready), 32'd0);
    checkOutput("rst_mid_lmfc",  32'(bus.lmfc_cnt),     32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
